freq_count_latch: RTL and testbench
===================================

# freq_count_latch

Gated decimal event counter with output latch: the measurement stage directly downstream of the frequency-meter control-signal generator. It consumes the generator's `enable` / `clear` / `latch` strobes and the range select. It counts rising edges of the measured signal through a range prescaler into a `DIGITS`-decade BCD counter, then presents a held reading and overflow flag to the display stage.

## Interface
- `DIGITS`, 6, number of BCD decades in counter and readout (≥1).
- `SYNC_STAGES`, 2, synchronizer flops on `sigIn` (≥2).
- `clkCount`  in  1  counting clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `sigIn`  in  1  measured signal, asynchronous to `clkCount`.
- `enable`  in  1  1 = count gate open.
- `clear`  in  1  active-low; 0 = zero counter, prescaler and live overflow.
- `latch`  in  1  0 = readout transparent (tracks counter), 1 = readout held.
- `testMode`  in  2  range: 0 = ÷1, 1 = ÷10, 2 = ÷100, 3 = ÷1000.
- `bcdOut`  out  4·DIGITS  held reading; digit 0 in bits [3:0].
- `overflow`  out  1  held overflow flag.
- `readyPulse`  out  1  one-cycle pulse when a new reading becomes held.

## Operation
- **Synchronizer:** `sigIn` passes through a `SYNC_STAGES` flop chain, then one history flop. The edge pulse is `synced & ~history`. Edges arriving while `enable = 0` are dropped, not deferred.
- **Priority each cycle:** `reset` > `clear = 0` > counting. When `clear = 0` and `enable = 1` in the same cycle, clear wins and that cycle's edge is lost.
- **Prescaler:** a 10-bit counter counts gated edges modulo N (N = 1/10/100/1000 from `testMode`). It emits a tick when it wraps from N-1 to 0; when N = 1, every gated edge is a tick.
  - A `testMode` change does not reset the prescaler by itself; the upstream generator always issues `clear` on a mode change.
  - If the prescaler value is ≥ the new N, the next gated edge wraps it to 0 with a tick.
- **BCD counter:** a tick increments the DIGITS-decade counter, with decimal carry 9→0 into the next decade.
  - At all-9s, a tick leaves the counter at all-9s (saturate) and sets the live overflow bit.
  - Live overflow is sticky until `clear = 0` or `reset`.
- **Readout register:**
  - While `latch = 0`, `bcdOut` and `overflow` load the live counter and live overflow every cycle.
  - While `latch = 1`, they hold.
  - `readyPulse` = 1 for exactly the cycle after `latch` is sampled 0→1.
- **Reset values:** `bcdOut` = 0, `overflow` = 0, `readyPulse` = 0, counter = 0, prescaler = 0, synchronizer and history flops = 0, previous-latch flop = 1. Because previous-latch resets to 1, there is no `readyPulse` on the first cycle after reset.

## Timing
- `sigIn` rising, set up before edge k → the synchronized value is high after edge k+SYNC_STAGES-1 → the edge pulse is valid in the following cycle → the counter updates at edge k+SYNC_STAGES.
- `enable` is sampled in the same cycle the edge pulse is high.
- Counter → `bcdOut`: one cycle (registered) while transparent.
- `latch` 1 at edge j: `bcdOut` holds the value loaded at edge j-1, i.e. the counter value before edge j-1's update.
- `readyPulse` is high for the cycle following edge j.
- `clear = 0` at edge j: counter = 0 after edge j; `bcdOut` = 0 after edge j+1 if transparent.
- `reset` asserted at any point, including mid-count or while held: all state takes reset values after the next edge.
- Maximum countable `sigIn` rate: one rising edge per 2 `clkCount` cycles. Faster inputs are undercounted; this is not flagged.

## Structure
- **Package `freq_pkg`:**
  - `bcd_digit_t` (4-bit).
  - Range encoding constants `RANGE_DIV1` … `RANGE_DIV1000`.
  - Divisor table function `range_div(testMode)` returning N-1 as 10 bits.
- **Sub-module `bcd_decade`:** one digit with `inc_in`, `clr_n`, digit register, `carry_out` (digit = 9 & `inc_in`) and `is_nine`.
  - Instantiated `DIGITS` times; the top-level ANDs `is_nine` across all decades for saturation and overflow.

## Test plan
- **Reset mid-count:** reset during counting with `latch = 0` → all outputs 0 the next cycle; pulses with `enable = 0` leave `bcdOut` = 0.
- **÷1 gated burst:** `testMode = 0`, `clear` pulse, `enable = 1`, 37 `sigIn` pulses (period 4 clocks), then `latch = 1` → `bcdOut` = 0x000037, one `readyPulse`, value held through a further 10 pulses.
- **÷10 prescale:** `testMode = 1`, 125 pulses → 12. Next 5 pulses → 13 (prescaler carried 5 → wraps at 10).
- **Saturation:** `DIGITS = 2`, ÷1, 105 pulses → `bcdOut` = 0x99, `overflow` = 1. `clear = 0` → 0x00, `overflow` = 0 after 2 cycles.
- **Clear/enable collision:** `clear = 0` and `enable = 1` in the cycle an edge pulse occurs → counter stays 0. `enable` dropped → edges during low `enable` are not counted afterwards.
- **Synchronizer latency:** single `sigIn` rise → counter changes exactly at edge k+SYNC_STAGES. Checked for `SYNC_STAGES` = 2 and 3.

Source files
------------

// File: rtl/freq_pkg.sv
// Shared types and range-select decoding for the frequency-meter counting stage.
package freq_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam logic [1:0] RANGE_DIV1    = 2'd0;
  localparam logic [1:0] RANGE_DIV10   = 2'd1;
  localparam logic [1:0] RANGE_DIV100  = 2'd2;
  localparam logic [1:0] RANGE_DIV1000 = 2'd3;

  localparam int PRESCALE_W = 10;

  // Returns N-1 so the prescaler compares directly against its current value.
  function automatic logic [PRESCALE_W-1:0] range_div(input logic [1:0] mode);
    logic [PRESCALE_W-1:0] r_div;
    case (mode)
      RANGE_DIV1:    r_div = 10'd0;
      RANGE_DIV10:   r_div = 10'd9;
      RANGE_DIV100:  r_div = 10'd99;
      RANGE_DIV1000: r_div = 10'd999;
      default:       r_div = 10'd0;
    endcase
    return r_div;
  endfunction

endpackage

// File: rtl/freq_count_latch_bcd_decade.sv
// One decimal decade of the event counter: 0..9 with ripple carry into the next decade.
module bcd_decade
  import freq_pkg::*;
(
  input  logic       clk,
  input  logic       srst,
  input  logic       clr_n,
  input  logic       inc_in,
  output bcd_digit_t digit,
  output logic       carry_out,
  output logic       is_nine
);

  bcd_digit_t r_digit;

  always_ff @(posedge clk) begin
    if (srst || !clr_n) begin
      r_digit <= '0;
    end else if (inc_in) begin
      r_digit <= (r_digit == 4'd9) ? 4'd0 : r_digit + 4'd1;
    end
  end

  assign digit     = r_digit;
  assign is_nine   = (r_digit == 4'd9);
  assign carry_out = is_nine & inc_in;

endmodule

// File: rtl/freq_count_latch.sv
// Gated, prescaled BCD event counter with a transparent/hold readout register.
module freq_count_latch
  import freq_pkg::*;
#(
  parameter int DIGITS      = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clkCount,
  input  logic                  reset,
  input  logic                  sigIn,
  input  logic                  enable,
  input  logic                  clear,
  input  logic                  latch,
  input  logic [1:0]            testMode,
  output logic [4*DIGITS-1:0]   bcdOut,
  output logic                  overflow,
  output logic                  readyPulse
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_hist;
  logic [PRESCALE_W-1:0]  r_pre;
  logic                   r_ovf_live;
  logic [4*DIGITS-1:0]    r_bcd;
  logic                   r_ovf;
  logic                   r_prev_latch;
  logic                   r_ready;

  logic                   w_edge;
  logic                   w_gated;
  logic [PRESCALE_W-1:0]  w_div;
  logic                   w_wrap;
  logic                   w_tick;
  logic [DIGITS:0]        w_carry;
  logic [DIGITS-1:0]      w_is_nine;
  logic                   w_all_nine;
  logic [4*DIGITS-1:0]    w_count;
  logic                   w_unused_top_carry;

  always_ff @(posedge clkCount) begin
    if (reset) begin
      r_sync <= '0;
      r_hist <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], sigIn};
      r_hist <= r_sync[SYNC_STAGES-1];
    end
  end

  // A low clear masks the edge so a colliding edge is lost rather than counted.
  assign w_edge  = r_sync[SYNC_STAGES-1] & ~r_hist;
  assign w_gated = w_edge & enable & clear;
  assign w_div   = range_div(testMode);
  assign w_wrap  = (r_pre >= w_div);
  assign w_tick  = w_gated & w_wrap;

  always_ff @(posedge clkCount) begin
    if (reset || !clear) begin
      r_pre <= '0;
    end else if (w_gated) begin
      r_pre <= w_wrap ? '0 : r_pre + 10'd1;
    end
  end

  // Increments are blocked at all-nines so the counter saturates instead of rolling over.
  assign w_carry[0] = w_tick & ~w_all_nine;

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_decade
      bcd_decade u_decade (
        .clk       (clkCount),
        .srst      (reset),
        .clr_n     (clear),
        .inc_in    (w_carry[gi]),
        .digit     (w_count[4*gi +: 4]),
        .carry_out (w_carry[gi+1]),
        .is_nine   (w_is_nine[gi])
      );
    end
  endgenerate

  assign w_all_nine         = &w_is_nine;
  assign w_unused_top_carry = w_carry[DIGITS];

  always_ff @(posedge clkCount) begin
    if (reset || !clear) begin
      r_ovf_live <= 1'b0;
    end else if (w_tick && w_all_nine) begin
      r_ovf_live <= 1'b1;
    end
  end

  always_ff @(posedge clkCount) begin
    if (reset) begin
      r_bcd        <= '0;
      r_ovf        <= 1'b0;
      r_prev_latch <= 1'b1;
      r_ready      <= 1'b0;
    end else begin
      if (!latch) begin
        r_bcd <= w_count;
        r_ovf <= r_ovf_live;
      end
      r_prev_latch <= latch;
      r_ready      <= latch & ~r_prev_latch;
    end
  end

  assign bcdOut     = r_bcd;
  assign overflow   = r_ovf;
  assign readyPulse = r_ready;

endmodule

// File: tb/tb_freq_count_latch.sv
// Randomised and directed bench for freq_count_latch with an integer reference model and scoreboard.
module tb_freq_count_latch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, sig, en, clr, lat;
  logic [1:0] mode;
  logic [23:0] bcd0;
  logic [7:0]  bcd1;
  logic        ovf0, ovf1, rdy0, rdy1;

  freq_count_latch #(.DIGITS(6), .SYNC_STAGES(2)) dut0 (
    .clkCount(clk), .reset(reset), .sigIn(sig), .enable(en), .clear(clr),
    .latch(lat), .testMode(mode), .bcdOut(bcd0), .overflow(ovf0), .readyPulse(rdy0)
  );

  freq_count_latch #(.DIGITS(2), .SYNC_STAGES(3)) dut1 (
    .clkCount(clk), .reset(reset), .sigIn(sig), .enable(en), .clear(clr),
    .latch(lat), .testMode(mode), .bcdOut(bcd1), .overflow(ovf1), .readyPulse(rdy1)
  );

  typedef struct {
    logic [23:0] bcd;
    logic        ovf;
    logic        rdy;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc_n = 0;

  // Reference model state: plain integers for count and prescale, a sample history of sigIn.
  int m_cnt[2], m_pre[2], m_out[2];
  bit m_ovf[2], m_oovf[2], m_rdy[2], m_plat[2];
  bit m_hist[2][8];

  function automatic int stages(input int d);
    return (d == 0) ? 2 : 3;
  endfunction

  function automatic int max_count(input int d);
    return (d == 0) ? 999999 : 99;
  endfunction

  function automatic int divisor(input logic [1:0] m);
    case (m)
      2'd0: return 1;
      2'd1: return 10;
      2'd2: return 100;
      default: return 1000;
    endcase
  endfunction

  function automatic logic [23:0] to_bcd(input int v);
    logic [23:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < 6; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic model_step(input int d);
    bit   e;
    exp_t x;
    int   s;
    s = stages(d);
    if (reset) begin
      m_cnt[d] = 0; m_pre[d] = 0; m_ovf[d] = 0;
      m_out[d] = 0; m_oovf[d] = 0; m_rdy[d] = 0; m_plat[d] = 1;
      for (int k = 0; k < 8; k++) m_hist[d][k] = 0;
    end else begin
      // A rising edge on sigIn reaches the counter S samples later.
      e = m_hist[d][s-1] & ~m_hist[d][s];
      for (int k = 7; k > 0; k--) m_hist[d][k] = m_hist[d][k-1];
      m_hist[d][0] = sig;
      m_rdy[d]  = lat & ~m_plat[d];
      m_plat[d] = lat;
      if (!lat) begin
        m_out[d]  = m_cnt[d];
        m_oovf[d] = m_ovf[d];
      end
      if (!clr) begin
        m_cnt[d] = 0; m_pre[d] = 0; m_ovf[d] = 0;
      end else if (e && en) begin
        if (m_pre[d] >= divisor(mode) - 1) begin
          m_pre[d] = 0;
          if (m_cnt[d] == max_count(d)) m_ovf[d] = 1;
          else m_cnt[d] = m_cnt[d] + 1;
        end else begin
          m_pre[d] = m_pre[d] + 1;
        end
      end
    end
    x.bcd = to_bcd(m_out[d]);
    x.ovf = m_oovf[d];
    x.rdy = m_rdy[d];
    if (d == 0) q0.push_back(x);
    else        q1.push_back(x);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
  endtask

  task automatic pulses(input int n, input int hi, input int lo);
    repeat (n) begin
      sig = 1'b1;
      repeat (hi) cyc();
      sig = 1'b0;
      repeat (lo) cyc();
    end
  endtask

  task automatic clear_pulse(input logic [1:0] new_mode);
    clr  = 1'b0;
    mode = new_mode;
    cyc();
    clr  = 1'b1;
  endtask

  task automatic check(input int d, input exp_t x, input logic [23:0] g_bcd,
                       input logic g_ovf, input logic g_rdy);
    n_cmp++;
    if (g_bcd !== x.bcd || g_ovf !== x.ovf || g_rdy !== x.rdy) begin
      n_bad++;
      $display("FAIL dut%0d_readout cycle %0d: got bcd=%h ovf=%b rdy=%b, expected bcd=%h ovf=%b rdy=%b",
               d, cyc_n, g_bcd, g_ovf, g_rdy, x.bcd, x.ovf, x.rdy);
    end
  endtask

  exp_t e0, e1;
  always @(negedge clk) begin
    cyc_n++;
    if (q0.size() > 0) begin
      e0 = q0.pop_front();
      check(0, e0, bcd0, ovf0, rdy0);
    end
    if (q1.size() > 0) begin
      e1 = q1.pop_front();
      check(1, e1, {16'h0, bcd1}, ovf1, rdy1);
    end
  end

  initial begin
    reset = 1'b1; sig = 1'b0; en = 1'b0; clr = 1'b1; lat = 1'b0; mode = 2'd0;
    repeat (3) cyc();
    reset = 1'b0;
    repeat (2) cyc();

    // Reset in the middle of counting, then edges with the gate closed.
    en = 1'b1;
    pulses(6, 2, 2);
    reset = 1'b1; cyc(); reset = 1'b0;
    en = 1'b0;
    pulses(4, 2, 2);
    repeat (3) cyc();

    // Divide-by-1 burst, then hold the reading while more edges arrive.
    clear_pulse(2'd0);
    en = 1'b1;
    pulses(37, 2, 2);
    repeat (4) cyc();
    lat = 1'b1;
    pulses(10, 2, 2);
    lat = 1'b0;
    repeat (3) cyc();

    // Divide-by-10: 125 edges, then 5 more completing the partial prescale.
    clear_pulse(2'd1);
    pulses(125, 2, 2);
    repeat (4) cyc();
    pulses(5, 2, 2);
    repeat (4) cyc();

    // Saturation of the two-digit instance.
    clear_pulse(2'd0);
    pulses(105, 2, 2);
    repeat (4) cyc();
    clear_pulse(2'd0);
    repeat (3) cyc();

    // Clear held low across the cycles where the edge pulse lands.
    sig = 1'b1; cyc();
    clr = 1'b0;
    repeat (3) cyc();
    clr = 1'b1;
    repeat (2) cyc();
    sig = 1'b0;
    repeat (3) cyc();

    // Gate dropped: edges during low enable must never appear later.
    en = 1'b0;
    pulses(5, 2, 2);
    en = 1'b1;
    repeat (4) cyc();
    pulses(3, 1, 3);
    repeat (4) cyc();

    // Randomised traffic over all inputs; range only changes under clear.
    for (int i = 0; i < 1200; i++) begin
      int r;
      r = $urandom_range(0, 199);
      reset = (r == 0);
      if (r >= 1 && r < 5) begin
        clr  = 1'b0;
        mode = 2'($urandom_range(0, 3));
      end else begin
        clr = 1'b1;
      end
      if ($urandom_range(0, 19) == 0) en  = ~en;
      if ($urandom_range(0, 24) == 0) lat = ~lat;
      if ($urandom_range(0, 2) == 0)  sig = ~sig;
      cyc();
    end
    reset = 1'b0; clr = 1'b1;
    repeat (3) cyc();

    repeat (4) @(negedge clk);
    n_cmp++;
    if (q0.size() != 0 || q1.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d/%0d pending, expected 0/0", q0.size(), q1.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
